// File: rtl/friscv_rv32i_encoder.sv
// friscv_rv32i_encoder: packs RV32I fields into instruction words through a 2-entry FIFO.
// Statistics counters are built only when FRISCV_ENCODER_STATS_EN is defined.
module friscv_rv32i_encoder #(
    parameter int XLEN = 32
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_format,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] imm,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic            inst_error,
    output logic [31:0]     inst_count,
    output logic [15:0]     err_count
);
    logic [XLEN-1:0] word;
    logic            bad;
    logic            fit12, fit13, fit21;
    logic [XLEN:0]   mem [2];
    logic            wr_ptr, rd_ptr, up;
    logic [1:0]      count;
    logic            push, pop;

    // An immediate fits in N signed bits when bits [31:N-1] are all copies of the sign.
    assign fit12 = &imm[31:11] | ~|imm[31:11];
    assign fit13 = &imm[31:12] | ~|imm[31:12];
    assign fit21 = &imm[31:20] | ~|imm[31:20];

    always_comb begin
        word = '0;
        bad  = 1'b0;
        case (req_format)
            3'd0: word = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                bad  = !fit12;
            end
            3'd2: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                bad  = !fit12;
            end
            3'd3: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                bad  = !fit13 || imm[0];
            end
            3'd4: begin
                word = {imm[31:12], rd, opcode};
                bad  = |imm[11:0];
            end
            3'd5: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                bad  = !fit21 || imm[0];
            end
            default: bad = 1'b1;
        endcase
    end

    assign push       = req_valid && req_ready;
    assign pop        = inst_valid && inst_ready;
    assign req_ready  = up && count != 2'd2;
    assign inst_valid = count != 2'd0;
    // Outputs are gated by occupancy so storage needs no reset.
    assign inst       = inst_valid ? mem[rd_ptr][XLEN-1:0] : '0;
    assign inst_error = inst_valid && mem[rd_ptr][XLEN];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            up     <= 1'b0;
        end else begin
            up     <= 1'b1;
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr] <= {bad, word & {XLEN{!bad}}};
    end

`ifdef FRISCV_ENCODER_STATS_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            inst_count <= '0;
            err_count  <= '0;
        end else if (pop) begin
            inst_count <= inst_count + 32'd1;
            if (inst_error && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`else
    assign inst_count = '0;
    assign err_count  = '0;
`endif
endmodule

// File: tb/tb_friscv_rv32i_encoder.sv
// tb_friscv_rv32i_encoder: directed vectors with hand-computed encodings.
// Inputs are driven and outputs sampled on the falling edge.
module tb_friscv_rv32i_encoder;
`ifdef FRISCV_ENCODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic        aclk = 1'b0, aresetn, req_valid, req_ready, inst_valid, inst_ready, inst_error;
    logic [2:0]  req_format, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, inst, inst_count;
    logic [15:0] err_count;
    int n_vec = 0, n_bad = 0, exp_ic = 0, exp_ec = 0;

    friscv_rv32i_encoder #(.XLEN(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_format(req_format), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_error(inst_error),
        .inst_count(inst_count), .err_count(err_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d, input logic [31:0] im);
        req_format = f; opcode = op; funct3 = 3'd0; funct7 = 7'd0;
        rs1 = r1; rs2 = r2; rd = d; imm = im; req_valid = 1'b1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_inst_count"}, inst_count, STATS ? 32'(exp_ic) : 32'd0);
        check({tag, "_err_count"}, {16'd0, err_count}, STATS ? 32'(exp_ec) : 32'd0);
    endtask

    task automatic vec(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [31:0] im, input logic [31:0] exp, input logic e);
        @(negedge aclk);
        drive(f, op, 5'd0, 5'd0, d, im);
        @(negedge aclk);
        req_valid = 1'b0;
        check($sformatf("valid f%0d imm %h", f, im), 32'(inst_valid), 32'd1);
        check($sformatf("inst f%0d imm %h", f, im), inst, exp);
        check($sformatf("err f%0d imm %h", f, im), 32'(inst_error), 32'(e));
        exp_ic++;
        if (e) exp_ec++;
    endtask

    initial begin
        aresetn = 1'b0; inst_ready = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        req_valid = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_err", 32'(inst_error), 32'd0);
        check_stats("rst");
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        inst_ready = 1'b1;

        vec(3'd1, 7'h13, 5'd1, 32'd5, 32'h00500093, 1'b0);

        @(negedge aclk);
        drive(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 32'd0);
        @(negedge aclk);
        check("r_inst", inst, 32'h002081B3);
        drive(3'd5, 7'h6F, 5'd0, 5'd0, 5'd1, 32'd8);
        @(negedge aclk);
        req_valid = 1'b0;
        check("j_inst", inst, 32'h008000EF);
        check("j_valid", 32'(inst_valid), 32'd1);
        @(negedge aclk);
        check("rj_drained", 32'(inst_valid), 32'd0);
        exp_ic += 2;

        drive(3'd3, 7'h63, 5'd1, 5'd2, 5'd0, -32'sd4);
        @(negedge aclk);
        check("b_inst", inst, 32'hFE208EE3);
        check("b_err", 32'(inst_error), 32'd0);
        imm = 32'd3;
        @(negedge aclk);
        req_valid = 1'b0;
        check("b_odd_inst", inst, 32'd0);
        check("b_odd_err", 32'(inst_error), 32'd1);
        @(negedge aclk);
        exp_ic += 2; exp_ec += 1;
        check_stats("b");

        vec(3'd6, 7'h13, 5'd0, 32'd0, 32'd0, 1'b1);
        vec(3'd7, 7'h13, 5'd0, 32'd0, 32'd0, 1'b1);
        vec(3'd1, 7'h13, 5'd0, 32'd2047, 32'h7FF00013, 1'b0);
        vec(3'd1, 7'h13, 5'd0, -32'sd2048, 32'h80000013, 1'b0);
        vec(3'd1, 7'h13, 5'd0, 32'd2048, 32'd0, 1'b1);
        vec(3'd2, 7'h23, 5'd0, -32'sd1, 32'hFE000FA3, 1'b0);
        vec(3'd2, 7'h23, 5'd0, -32'sd2049, 32'd0, 1'b1);
        vec(3'd3, 7'h63, 5'd0, 32'd4094, 32'h7E000FE3, 1'b0);
        vec(3'd3, 7'h63, 5'd0, -32'sd4096, 32'h80000063, 1'b0);
        vec(3'd3, 7'h63, 5'd0, 32'd4096, 32'd0, 1'b1);
        vec(3'd3, 7'h63, 5'd0, -32'sd4098, 32'd0, 1'b1);
        vec(3'd5, 7'h6F, 5'd0, 32'd1048574, 32'h7FFFF06F, 1'b0);
        vec(3'd5, 7'h6F, 5'd0, -32'sd1048576, 32'h8000006F, 1'b0);
        vec(3'd5, 7'h6F, 5'd0, 32'd1048576, 32'd0, 1'b1);
        vec(3'd5, 7'h6F, 5'd0, 32'd3, 32'd0, 1'b1);
        vec(3'd4, 7'h37, 5'd5, 32'h12345000, 32'h123452B7, 1'b0);
        vec(3'd4, 7'h37, 5'd5, 32'h12345001, 32'd0, 1'b1);
        @(negedge aclk);
        check_stats("table");

        inst_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd1, 32'd1);
        @(negedge aclk);
        imm = 32'd2;
        @(negedge aclk);
        check("bp_ready_full", 32'(req_ready), 32'd0);
        check("bp_head_a", inst, 32'h00100093);
        imm = 32'd3;
        @(negedge aclk);
        check("bp_still_full", 32'(req_ready), 32'd0);
        check("bp_stable_a", inst, 32'h00100093);
        check("bp_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        @(negedge aclk);
        check("bp_head_b", inst, 32'h00200093);
        check("bp_ready_again", 32'(req_ready), 32'd1);
        @(negedge aclk);
        req_valid = 1'b0;
        check("bp_head_c", inst, 32'h00300093);
        @(negedge aclk);
        check("bp_drained", 32'(inst_valid), 32'd0);
        exp_ic += 3;

        inst_ready = 1'b0;
        drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd1, 32'd7);
        @(negedge aclk);
        imm = 32'd9;
        @(negedge aclk);
        req_valid = 1'b0;
        check("mid_valid", 32'(inst_valid), 32'd1);
        check_stats("mid");
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        exp_ic = 0; exp_ec = 0;
        check("mr_valid", 32'(inst_valid), 32'd0);
        check("mr_ready", 32'(req_ready), 32'd0);
        check("mr_inst", inst, 32'd0);
        check_stats("mr");
        @(negedge aclk);
        check("mr_ready_back", 32'(req_ready), 32'd1);
        check("mr_no_partial", 32'(inst_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
